data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the processor's data-memory port: a 64-bit-word data memory that accepts one load/store request at a time over a valid/ready handshake, applies a configurable wait-state latency, commits the access, then returns a response over a second valid/ready handshake. It replaces the zero-latency data memory when the datapath is moved to a handshaked memory interface. It also rejects misaligned and out-of-range addresses with an error response.

## Interface
- DEPTH, 1024: number of 64-bit words; the valid byte-address range is 0 to DEPTH*8-1.
- LATENCY, 2: wait states between request acceptance and memory commit (0 to 15).
- CLK  input  1  clock; all state changes on the rising edge.
- resetl  input  1  reset, synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address.
- req_wdata  input  64  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  64  load data; 0 for stores and errors.
- resp_err  output  1  access rejected.

## Operation
- States: IDLE, WAIT, RESP. The reset state is IDLE.
- Reset values: req_ready=1 (IDLE), resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Memory array contents are not cleared by reset.
- **IDLE**
  - req_ready=1.
  - On req_valid=1: latch write, addr and wdata, and evaluate the error condition.
  - Error condition: req_addr[2:0]!=0, or req_addr[63:3] >= DEPTH.
- **Transitions out of IDLE**
  - Error: go to RESP with resp_err=1 and resp_rdata=0. No memory access, no wait states.
  - Otherwise, LATENCY=0: commit at the acceptance edge, then go to RESP.
  - Otherwise, LATENCY>=1: go to WAIT with counter=LATENCY-1.
- **WAIT**
  - req_ready=0. req_* inputs are ignored; the latched copy is used.
  - counter!=0: decrement.
  - counter==0: commit and go to RESP.
- **Commit**
  - Store: mem[addr[63:3]] <= wdata; resp_rdata=0.
  - Load: resp_rdata <= mem[addr[63:3]].
  - resp_err=0 in both cases.
- **RESP**
  - resp_valid=1; resp_rdata and resp_err stay stable until the handshake.
  - On resp_ready=1: go to IDLE, resp_valid=0, and resp_rdata and resp_err cleared to 0.
  - req_ready does not rise in the same cycle (no same-cycle turnaround).
- **Reset mid-operation**
  - From any state: return to IDLE and drop any pending response.
  - A store still in WAIT is discarded and memory is unchanged.
  - A store already committed stays committed.
- **Ordering**: single outstanding request, so a load after a store to the same word always returns the stored data.

## Timing
- Acceptance edge T: the first rising edge with req_valid=1 in IDLE and resetl=0.
- Non-error access: commit at edge T+LATENCY; resp_valid high from just after T+LATENCY.
- Error access: resp_valid high from just after T.
- Response handshake edge R: resp_valid=1 and resp_ready=1. req_ready is high again from just after R.
- Minimum request period: LATENCY+2 cycles for a valid access (resp_ready held 1), 2 cycles for an error.
- resp_ready low holds RESP indefinitely with outputs frozen.
- resetl=1 overrides every other event on the same edge, including a request acceptance, a commit or a response handshake.

## Test plan
- **Store then load:** LATENCY=2, resp_ready=1.
  - Store 0x0123456789ABCDEF to addr 0x40 accepted at edge 1 -> resp_valid at edge 3, resp_err=0, resp_rdata=0.
  - Load 0x40 accepted at edge 5 -> resp_valid at edge 7 with resp_rdata=0x0123456789ABCDEF.
- **Backpressure:** load with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata held constant and req_ready=0 throughout. resp_ready=1 -> handshake, then req_ready=1 on the next cycle.
- **Errors:** with DEPTH=1024:
  - Load from 0x43 -> resp_err=1 one cycle after acceptance, resp_rdata=0.
  - Store to 0x2000 -> resp_err=1.
  - A subsequent load of word 0 returns its prior value unchanged.
- **LATENCY=0:** store 0x55 to 0x8 -> resp_valid one cycle after acceptance. An immediate load of 0x8 -> 0x55.
- **Reset mid-operation:**
  - Assert resetl during WAIT of a store of 0xFFFF to 0x10 -> IDLE, resp_valid=0. A later load of 0x10 returns the old value.
  - Assert resetl during RESP -> response dropped, req_ready=1.
- **Inputs ignored in WAIT:** change req_addr, req_wdata and req_write during WAIT -> the committed access uses the values latched at acceptance.

Source files
------------

// File: rtl/data_mem_responder.sv
// Handshaked 64-bit-word data memory responder: one outstanding load/store,
// programmable wait states, error response for misaligned or out-of-range addresses.
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    // state  | meaning
    // IDLE   | ready for a request
    // WAIT   | request latched, counting wait states
    // RESP   | response presented, waiting for resp_ready
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [63:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [63:0]      mem [DEPTH];

    logic             addr_err;
    logic [IDX_W-1:0] req_idx;
    logic             commit_en;
    logic             commit_wr;
    logic [IDX_W-1:0] commit_idx;
    logic [63:0]      commit_wdata;

    assign addr_err = (req_addr[2:0] != 3'd0) || (req_addr[63:3] >= 61'(DEPTH));
    assign req_idx  = req_addr[3 +: IDX_W];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        commit_en    = 1'b0;
        commit_wr    = write_q;
        commit_idx   = idx_q;
        commit_wdata = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    idx_d   = req_idx;
                    wdata_d = req_wdata;
                    if (addr_err) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        rdata_d = 64'd0;
                    end else if (LATENCY == 0) begin
                        // zero wait states: commit straight from the request inputs
                        commit_en    = 1'b1;
                        commit_wr    = req_write;
                        commit_idx   = req_idx;
                        commit_wdata = req_wdata;
                        state_d      = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit_en = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 64'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (commit_en) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (resetl) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            // registered read keeps the array mappable to synchronous RAM
            if (commit_en) begin
                rdata_q <= commit_wr ? 64'd0 : mem[commit_idx];
            end else begin
                rdata_q <= rdata_d;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetl && commit_en && commit_wr) begin
            mem[commit_idx] <= commit_wdata;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random traffic on a
// LATENCY=2 and a LATENCY=0 instance, checked against a word-array model.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;

    logic        CLK = 1'b0;
    logic        resetl;
    logic        req_valid, req_write, resp_ready;
    logic [63:0] req_addr, req_wdata;
    int          sel;

    logic        rr0, rv0, re0, rr1, rv1, re1;
    logic [63:0] rd0, rd1;
    logic        req_valid0, req_valid1;
    logic        req_ready_o, resp_valid_o, resp_err_o;
    logic [63:0] resp_rdata_o;

    int checks = 0;
    int errors = 0;

    bit [63:0] model_mem [2][DEPTH];
    bit        known     [2][DEPTH];
    int        lat_of    [2] = '{2, 0};

    assign req_valid0   = req_valid && (sel == 0);
    assign req_valid1   = req_valid && (sel == 1);
    assign req_ready_o  = (sel == 1) ? rr1 : rr0;
    assign resp_valid_o = (sel == 1) ? rv1 : rv0;
    assign resp_err_o   = (sel == 1) ? re1 : re0;
    assign resp_rdata_o = (sel == 1) ? rd1 : rd0;

    always #5 CLK = ~CLK;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
        .CLK(CLK), .resetl(resetl), .req_valid(req_valid0), .req_ready(rr0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv0), .resp_ready(resp_ready), .resp_rdata(rd0), .resp_err(re0)
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
        .CLK(CLK), .resetl(resetl), .req_valid(req_valid1), .req_ready(rr1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(re1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input logic [63:0] addr);
        return (addr % 8 != 0) || ((addr / 8) >= DEPTH);
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
        chk({tag, "_resp_valid"}, 64'(resp_valid_o), 64'd0);
        chk({tag, "_resp_rdata"}, resp_rdata_o, 64'd0);
        chk({tag, "_resp_err"}, 64'(resp_err_o), 64'd0);
    endtask

    // One full transaction; called and returns on a falling edge.
    task automatic xact(input int s, input bit wr, input logic [63:0] addr,
                        input logic [63:0] wdata, input int hold);
        bit          err;
        int          lat;
        int          idx;
        logic [63:0] exp_rd;
        sel    = s;
        err    = is_err(addr);
        lat    = err ? 0 : lat_of[s];
        idx    = int'((addr / 8) % DEPTH);
        exp_rd = 64'd0;
        if (!err && !wr) exp_rd = model_mem[s][idx];
        if (!err && wr) begin
            model_mem[s][idx] = wdata;
            known[s][idx]     = 1'b1;
        end
        #1;
        chk("idle_req_ready", 64'(req_ready_o), 64'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = (hold == 0);
        for (int k = 0; k <= lat; k++) begin
            @(negedge CLK);
            req_valid = (k < lat) ? 1'($urandom) : 1'b0;
            req_write = 1'($urandom);
            req_addr  = {$urandom, $urandom};
            req_wdata = {$urandom, $urandom};
            chk("busy_req_ready", 64'(req_ready_o), 64'd0);
            chk("resp_valid_timing", 64'(resp_valid_o), 64'(k == lat));
        end
        chk("resp_err", 64'(resp_err_o), 64'(err));
        chk("resp_rdata", resp_rdata_o, exp_rd);
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            chk("held_resp_valid", 64'(resp_valid_o), 64'd1);
            chk("held_req_ready", 64'(req_ready_o), 64'd0);
            chk("held_resp_rdata", resp_rdata_o, exp_rd);
            chk("held_resp_err", 64'(resp_err_o), 64'(err));
        end
        resp_ready = 1'b1;
        @(negedge CLK);
        chk_idle("after_handshake");
        resp_ready = 1'b0;
    endtask

    initial begin
        int          s, word, r, hold;
        bit          wr;
        logic [63:0] addr;

        resetl     = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        resp_ready = 1'b0;
        sel        = 0;
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            sel = i;
            #1;
            chk_idle("reset_state");
        end
        resetl = 1'b0;
        @(negedge CLK);

        // store then load, resp_ready held high
        xact(0, 1'b1, 64'h40, 64'h0123456789ABCDEF, 0);
        xact(0, 1'b0, 64'h40, 64'h0, 0);
        // backpressure
        xact(0, 1'b0, 64'h40, 64'h0, 5);
        // errors leave memory untouched
        xact(0, 1'b1, 64'h0, 64'hA5A5_5A5A_DEAD_BEEF, 0);
        xact(0, 1'b0, 64'h43, 64'h0, 0);
        xact(0, 1'b1, 64'h2000, 64'h1234, 1);
        xact(0, 1'b0, 64'h0, 64'h0, 0);
        xact(0, 1'b0, 64'h1FF8, 64'h0, 0);
        // zero-latency instance
        xact(1, 1'b1, 64'h8, 64'h55, 0);
        xact(1, 1'b0, 64'h8, 64'h0, 0);
        xact(1, 1'b1, 64'h3, 64'h77, 2);

        // reset during WAIT discards the store
        xact(0, 1'b1, 64'h10, 64'h1111, 0);
        sel = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10; req_wdata = 64'hFFFF;
        @(negedge CLK);
        req_valid = 1'b0;
        chk("wait_resp_valid", 64'(resp_valid_o), 64'd0);
        resetl = 1'b1;
        @(negedge CLK);
        chk_idle("reset_in_wait");
        resetl = 1'b0;
        xact(0, 1'b0, 64'h10, 64'h0, 0);

        // reset during RESP drops the response
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h40; resp_ready = 1'b0;
        repeat (3) @(negedge CLK);
        req_valid = 1'b0;
        chk("resp_before_reset", 64'(resp_valid_o), 64'd1);
        resetl = 1'b1;
        @(negedge CLK);
        chk_idle("reset_in_resp");

        // reset overrides an acceptance in IDLE
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h40; req_wdata = 64'hBAD;
        @(negedge CLK);
        req_valid = 1'b0;
        chk_idle("reset_blocks_accept");
        resetl = 1'b0;
        @(negedge CLK);
        chk_idle("after_reset");
        xact(0, 1'b0, 64'h40, 64'h0, 0);

        // random traffic across both instances
        for (int i = 0; i < 150; i++) begin
            s    = int'($urandom_range(0, 1));
            word = int'($urandom_range(0, 15));
            r    = int'($urandom_range(0, 9));
            hold = int'($urandom_range(0, 3));
            wr   = 1'($urandom);
            if (r == 0)      addr = 64'(word * 8 + int'($urandom_range(1, 7)));
            else if (r == 1) addr = 64'h2000 + 64'($urandom_range(0, 255)) * 8;
            else if (r == 2) addr = {$urandom | 32'h1, $urandom} & ~64'h7;
            else begin
                addr = 64'(word * 8);
                if (!known[s][word]) wr = 1'b1;
            end
            xact(s, wr, addr, {$urandom, $urandom}, hold);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
